fx_mac_lanes: RTL and testbench

- Multi-lane signed fixed-point multiply-accumulate engine. Each of LANES lanes computes a dot product over a variable-length frame of (weight, data) beats.
- Frame length is set per frame by last_i and bounded by KMAX; it is not a fixed compile-time count.
- Results get selectable rounding and saturation, and are presented with a valid/ready output handshake plus per-lane saturation flags.
- Sits between the operand fetch/buffer logic and the activation/write-back stage of the conv datapath.

---
 rtl/fx_mac_lanes.sv | 162 ++++++++++++++++
 tb/tb_fx_mac_lanes.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mac_lanes.sv
// fx_mac_lanes: LANES parallel signed fixed-point dot-product engines with frame control,
// rounding, saturation and a valid/ready result port. Define FX_MAC_LANES_RELU_EN for ReLU.
module fx_mac_lanes #(
  parameter int WIDTH    = 8,
  parameter int FRACTION = 4,
  parameter int LANES    = 4,
  parameter int KMAX     = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  input  logic                     last_i,
  input  logic [LANES*WIDTH-1:0]   win,
  input  logic [LANES*WIDTH-1:0]   din,
  input  logic [1:0]               rnd_mode_i,
  output logic [LANES*WIDTH-1:0]   acc_o,
  output logic [LANES-1:0]         sat_o,
  output logic                     kovf_o,
  output logic                     vld_o,
  input  logic                     rdy_i
);
  localparam int WA = 2*WIDTH + $clog2(KMAX) + 1;
  localparam int CW = $clog2(KMAX + 1);
  localparam logic [CW-1:0] KMAX_C = CW'(KMAX);
  localparam logic signed [WA:0] SAT_MAX = {{(WA-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [WA:0] SAT_MIN = {{(WA-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_kovf;
  logic          r_kovf_o;
  logic          r_vld;
  logic          w_accept;
  logic          w_clr;
  logic          w_fin;
  logic          w_kmax;
  logic [CW-1:0] w_cnt_nx;

  assign rdy_o    = (r_state == ST_ACC) & ~rst_i;
  assign w_accept = vld_i & rdy_o;
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_kmax   = (w_cnt_nx == KMAX_C);
  assign w_fin    = (r_state == ST_FIN);
  assign w_clr    = (r_state == ST_HOLD) & rdy_i;
  assign kovf_o   = r_kovf_o;
  assign vld_o    = r_vld;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_ACC;
      r_cnt    <= '0;
      r_kovf   <= 1'b0;
      r_kovf_o <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nx;
            if (last_i || w_kmax) r_state <= ST_DRAIN;
            if (w_kmax && !last_i) r_kovf <= 1'b1;
          end
        end
        // One idle cycle lets the final registered product reach the accumulator.
        ST_DRAIN: r_state <= ST_FIN;
        ST_FIN: begin
          r_kovf_o <= r_kovf;
          r_vld    <= 1'b1;
          r_state  <= ST_HOLD;
        end
        default: begin
          if (rdy_i) begin
            r_vld   <= 1'b0;
            r_cnt   <= '0;
            r_kovf  <= 1'b0;
            r_state <= ST_ACC;
          end
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [WIDTH-1:0]   w_w;
    logic signed [WIDTH-1:0]   w_d;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [2*WIDTH-1:0] r_prod;
    logic signed [WA-1:0]      r_acc;
    logic signed [WA-1:0]      w_shift;
    logic signed [WA:0]        w_rnd;
    logic                      w_g;
    logic                      w_s;
    logic                      w_lsb;
    logic                      w_inc;
    logic                      w_hi;
    logic                      w_lo;
    logic [WIDTH-1:0]          w_clip;
    logic [WIDTH-1:0]          w_res;
    logic [WIDTH-1:0]          r_res;
    logic                      r_sat;

    assign w_w     = win[gi*WIDTH +: WIDTH];
    assign w_d     = din[gi*WIDTH +: WIDTH];
    assign w_prod  = w_w * w_d;
    assign w_shift = r_acc >>> FRACTION;
    assign w_g     = r_acc[FRACTION-1];
    assign w_lsb   = r_acc[FRACTION];

    if (FRACTION > 1) begin : g_sticky
      assign w_s = |r_acc[FRACTION-2:0];
    end else begin : g_no_sticky
      assign w_s = 1'b0;
    end

    always_comb begin
      w_inc = w_g;
      case (rnd_mode_i)
        2'd0:    w_inc = 1'b0;
        2'd2:    w_inc = w_g & (w_s | w_lsb);
        default: w_inc = w_g;
      endcase
    end

    assign w_rnd  = {w_shift[WA-1], w_shift} + {{WA{1'b0}}, w_inc};
    assign w_hi   = w_rnd > SAT_MAX;
    assign w_lo   = w_rnd < SAT_MIN;
    assign w_clip = w_hi ? SAT_MAX[WIDTH-1:0] : (w_lo ? SAT_MIN[WIDTH-1:0] : w_rnd[WIDTH-1:0]);

`ifdef FX_MAC_LANES_RELU_EN
    assign w_res = w_clip[WIDTH-1] ? '0 : w_clip;
`else
    assign w_res = w_clip;
`endif

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_prod <= '0;
        r_acc  <= '0;
        r_res  <= '0;
        r_sat  <= 1'b0;
      end else begin
        r_prod <= w_accept ? w_prod : '0;
        if (w_clr) r_acc <= '0;
        else       r_acc <= r_acc + {{(WA-2*WIDTH){r_prod[2*WIDTH-1]}}, r_prod};
        if (w_fin) begin
          r_res <= w_res;
          r_sat <= w_hi | w_lo;
        end
      end
    end

    assign acc_o[gi*WIDTH +: WIDTH] = r_res;
    assign sat_o[gi]                = r_sat;
  end

endmodule

// File: tb/tb_fx_mac_lanes.sv
// Self-checking bench for fx_mac_lanes: directed corner cases plus randomized frames
// checked against an integer-arithmetic dot-product / rounding / clamping model.
module tb_fx_mac_lanes;
  localparam int WIDTH    = 8;
  localparam int FRACTION = 4;
  localparam int LANES    = 4;
  localparam int KMAX     = 9;
  localparam int LW       = LANES*WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          vld_i;
  logic          rdy_o;
  logic          last_i;
  logic [LW-1:0] win;
  logic [LW-1:0] din;
  logic [1:0]    rnd_mode_i;
  logic [LW-1:0] acc_o;
  logic [LANES-1:0] sat_o;
  logic          kovf_o;
  logic          vld_o;
  logic          rdy_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] fw[$];
  logic [LW-1:0] fd[$];

  fx_mac_lanes #(.WIDTH(WIDTH), .FRACTION(FRACTION), .LANES(LANES), .KMAX(KMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vld_i(vld_i), .rdy_o(rdy_o), .last_i(last_i),
    .win(win), .din(din), .rnd_mode_i(rnd_mode_i), .acc_o(acc_o), .sat_o(sat_o),
    .kovf_o(kovf_o), .vld_o(vld_o), .rdy_i(rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Reference: exact integer dot product, floor/remainder based rounding, clamp, optional ReLU.
  function automatic void ref_frame(input int n, input logic [1:0] mode,
                                    output logic [LW-1:0] e_acc, output logic [LANES-1:0] e_sat);
    longint sum, q, r, half, maxv, minv;
    int wv, dv;
    e_acc = '0;
    e_sat = '0;
    half = longint'(1) <<< (FRACTION-1);
    maxv = (longint'(1) <<< (WIDTH-1)) - 1;
    minv = -(longint'(1) <<< (WIDTH-1));
    for (int l = 0; l < LANES; l++) begin
      sum = 0;
      for (int b = 0; b < n; b++) begin
        wv = $signed(fw[b][l*WIDTH +: WIDTH]);
        dv = $signed(fd[b][l*WIDTH +: WIDTH]);
        sum += longint'(wv) * longint'(dv);
      end
      q = sum >>> FRACTION;
      r = sum - (q <<< FRACTION);
      if (mode == 2'd2) begin
        if (r > half || (r == half && q[0])) q++;
      end else if (mode != 2'd0) begin
        if (r >= half) q++;
      end
      if (q > maxv) begin
        q = maxv;
        e_sat[l] = 1'b1;
      end else if (q < minv) begin
        q = minv;
        e_sat[l] = 1'b1;
      end
`ifdef FX_MAC_LANES_RELU_EN
      if (q < 0) q = 0;
`endif
      e_acc[l*WIDTH +: WIDTH] = q[WIDTH-1:0];
    end
  endfunction

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  task automatic push_rand(input int n);
    for (int b = 0; b < n; b++) begin
      fw.push_back(rand_vec());
      fd.push_back(rand_vec());
    end
  endtask

  // Present fw/fd[0..n-1]; returns one cycle after the last beat is accepted.
  task automatic drive_beats(input int n, input bit last_at_end);
    int guard;
    for (int b = 0; b < n; b++) begin
      vld_i  = 1'b1;
      win    = fw[b];
      din    = fd[b];
      last_i = last_at_end && (b == n-1);
      guard  = 0;
      while (!rdy_o && guard < 50) begin
        tick;
        guard++;
      end
      if (guard >= 50) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL beat_accept_timeout beat=%0d rdy_o=%b required 1", b, rdy_o);
      end
      tick;
    end
    vld_i  = 1'b0;
    last_i = 1'b0;
  endtask

  // Latency in cycles counted from the cycle the last beat was presented.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!vld_o && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic consume;
    rdy_i = 1'b1;
    tick;
    rdy_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick;
    tick;
    n_tests++;
    if (rdy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rdy_during got=%b exp=0", rdy_o); end
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy_after got=%b exp=1", rdy_o); end
    n_tests++;
    if ({vld_o, kovf_o, sat_o, acc_o} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs vld=%b kovf=%b sat=%b acc=%h exp all 0", vld_o, kovf_o, sat_o, acc_o);
    end
    $display("[TB] reset: rdy=%b vld=%b acc=%h", rdy_o, vld_o, acc_o);
  endtask

  task automatic test_basic;
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    logic [LW-1:0] v;
    int lat;
    fw.delete(); fd.delete();
    for (int b = 0; b < 3; b++) begin
      v = rand_vec(); v[WIDTH-1:0] = 8'd16; fw.push_back(v);
      v = rand_vec(); v[WIDTH-1:0] = 8'd16; fd.push_back(v);
    end
    rnd_mode_i = 2'd1;
    drive_beats(3, 1'b1);
    wait_result(lat);
    ref_frame(3, 2'd1, e_acc, e_sat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=3", lat); end
    n_tests++;
    if (acc_o[WIDTH-1:0] !== 8'd48) begin n_fail++; $display("[TB] FAIL basic_lane0 got=%h exp=30", acc_o[WIDTH-1:0]); end
    n_tests++;
    if (acc_o !== e_acc || sat_o !== e_sat || kovf_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_result acc=%h sat=%b kovf=%b exp acc=%h sat=%b kovf=0", acc_o, sat_o, kovf_o, e_acc, e_sat);
    end
    $display("[TB] basic: lat=%0d acc=%h sat=%b kovf=%b", lat, acc_o, sat_o, kovf_o);
    consume;
  endtask

  task automatic test_rounding;
    int         tw[8] = '{1, 1, 1, 1, 1, 1, -1, -1};
    int         td[8] = '{8, 8, 8, 24, 24, 24, 8, 8};
    logic [1:0] tm[8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [7:0] te[8] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h02, 8'hFF, 8'h00};
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    logic [LW-1:0] v;
    int lat;
    for (int i = 0; i < 8; i++) begin
      fw.delete(); fd.delete();
      v = '0; v[WIDTH-1:0] = WIDTH'(tw[i]); fw.push_back(v);
      v = '0; v[WIDTH-1:0] = WIDTH'(td[i]); fd.push_back(v);
      rnd_mode_i = tm[i];
      drive_beats(1, 1'b1);
      wait_result(lat);
      ref_frame(1, tm[i], e_acc, e_sat);
      n_tests++;
      if (acc_o[WIDTH-1:0] !== te[i] || sat_o !== '0) begin
        n_fail++;
        $display("[TB] FAIL round_%0d lane0=%h sat=%b exp lane0=%h sat=0", i, acc_o[WIDTH-1:0], sat_o, te[i]);
      end
      n_tests++;
      if (acc_o !== e_acc || lat !== 3) begin
        n_fail++;
        $display("[TB] FAIL round_model_%0d acc=%h lat=%0d exp acc=%h lat=3", i, acc_o, lat, e_acc);
      end
      $display("[TB] round %0d: w=%0d d=%0d mode=%0d lane0=%h", i, tw[i], td[i], tm[i], acc_o[WIDTH-1:0]);
      consume;
    end
  endtask

  task automatic test_saturation;
    logic [WIDTH-1:0] e_lane;
    logic [WIDTH-1:0] wval;
    int lat;
    for (int c = 0; c < 2; c++) begin
      fw.delete(); fd.delete();
      wval = (c == 0) ? 8'd127 : 8'h80;
`ifdef FX_MAC_LANES_RELU_EN
      e_lane = (c == 0) ? 8'h7F : 8'h00;
`else
      e_lane = (c == 0) ? 8'h7F : 8'h80;
`endif
      for (int b = 0; b < KMAX; b++) begin
        fw.push_back({LANES{wval}});
        fd.push_back({LANES{8'd127}});
      end
      rnd_mode_i = 2'd1;
      drive_beats(KMAX, 1'b1);
      wait_result(lat);
      n_tests++;
      if (acc_o !== {LANES{e_lane}} || sat_o !== {LANES{1'b1}} || kovf_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL sat_%0d acc=%h sat=%b kovf=%b exp acc=%h sat=1111 kovf=0", c, acc_o, sat_o, kovf_o, {LANES{e_lane}});
      end
      $display("[TB] sat %0d: acc=%h sat=%b", c, acc_o, sat_o);
      consume;
    end
  endtask

  task automatic test_kovf;
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    int lat;
    fw.delete(); fd.delete();
    push_rand(KMAX + 1);
    rnd_mode_i = 2'd0;
    drive_beats(KMAX, 1'b0);
    // Beat 10 stays presented, flagged last, and must wait for the next frame.
    vld_i = 1'b1; win = fw[KMAX]; din = fd[KMAX]; last_i = 1'b1;
    n_tests++;
    if (rdy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL kovf_rdy got=%b exp=0", rdy_o); end
    wait_result(lat);
    ref_frame(KMAX, 2'd0, e_acc, e_sat);
    n_tests++;
    if (acc_o !== e_acc || sat_o !== e_sat || kovf_o !== 1'b1 || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL kovf_frame acc=%h sat=%b kovf=%b lat=%0d exp acc=%h sat=%b kovf=1 lat=3", acc_o, sat_o, kovf_o, lat, e_acc, e_sat);
    end
    $display("[TB] kovf: acc=%h kovf=%b", acc_o, kovf_o);
    consume;
    tick;
    vld_i = 1'b0; last_i = 1'b0;
    for (int b = 0; b < KMAX; b++) begin
      void'(fw.pop_front());
      void'(fd.pop_front());
    end
    wait_result(lat);
    ref_frame(1, 2'd0, e_acc, e_sat);
    n_tests++;
    if (acc_o !== e_acc || sat_o !== e_sat || kovf_o !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL kovf_next acc=%h sat=%b kovf=%b lat=%0d exp acc=%h sat=%b kovf=0 lat=3", acc_o, sat_o, kovf_o, lat, e_acc, e_sat);
    end
    $display("[TB] kovf next: acc=%h kovf=%b", acc_o, kovf_o);
    consume;
  endtask

  task automatic test_hold_stall;
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    int lat;
    fw.delete(); fd.delete();
    push_rand(2);
    rnd_mode_i = 2'd2;
    drive_beats(2, 1'b1);
    wait_result(lat);
    ref_frame(2, 2'd2, e_acc, e_sat);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (vld_o !== 1'b1 || acc_o !== e_acc || sat_o !== e_sat || rdy_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_%0d vld=%b acc=%h sat=%b rdy=%b exp vld=1 acc=%h sat=%b rdy=0", c, vld_o, acc_o, sat_o, rdy_o, e_acc, e_sat);
      end
      tick;
    end
    consume;
    n_tests++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_release vld=%b rdy=%b exp vld=0 rdy=1", vld_o, rdy_o);
    end
    $display("[TB] hold: acc=%h held 5 cycles", e_acc);
    fw.delete(); fd.delete();
    push_rand(1);
    drive_beats(1, 1'b1);
    wait_result(lat);
    ref_frame(1, 2'd2, e_acc, e_sat);
    n_tests++;
    if (acc_o !== e_acc || sat_o !== e_sat || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL hold_next acc=%h sat=%b lat=%0d exp acc=%h sat=%b lat=3", acc_o, sat_o, lat, e_acc, e_sat);
    end
    consume;
  endtask

  task automatic test_reset_midframe;
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    logic [LW-1:0] v;
    int lat;
    fw.delete(); fd.delete();
    push_rand(2);
    rnd_mode_i = 2'd0;
    drive_beats(2, 1'b0);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (vld_o !== 1'b0 || acc_o !== '0 || sat_o !== '0 || kovf_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midrst_%0d vld=%b acc=%h sat=%b kovf=%b exp all 0", c, vld_o, acc_o, sat_o, kovf_o);
      end
      tick;
    end
    fw.delete(); fd.delete();
    v = rand_vec(); v[WIDTH-1:0] = 8'd16; fw.push_back(v);
    v = rand_vec(); v[WIDTH-1:0] = 8'd32; fd.push_back(v);
    drive_beats(1, 1'b1);
    wait_result(lat);
    ref_frame(1, 2'd0, e_acc, e_sat);
    n_tests++;
    if (acc_o[WIDTH-1:0] !== 8'd32 || acc_o !== e_acc || sat_o !== e_sat || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL midrst_next acc=%h sat=%b lat=%0d exp acc=%h (lane0 20) sat=%b lat=3", acc_o, sat_o, lat, e_acc, e_sat);
    end
    $display("[TB] midframe reset: next acc=%h", acc_o);
    consume;
  endtask

  task automatic test_back_to_back;
    logic [LW-1:0] e_acc;
    logic [LANES-1:0] e_sat;
    logic [1:0] mode;
    int n, lat, stall;
    for (int f = 0; f < 10; f++) begin
      n     = $urandom_range(1, KMAX);
      mode  = 2'($urandom_range(0, 3));
      stall = $urandom_range(0, 3);
      fw.delete(); fd.delete();
      push_rand(n);
      rnd_mode_i = mode;
      drive_beats(n, 1'b1);
      wait_result(lat);
      ref_frame(n, mode, e_acc, e_sat);
      n_tests++;
      if (acc_o !== e_acc || sat_o !== e_sat || kovf_o !== 1'b0 || lat !== 3) begin
        n_fail++;
        $display("[TB] FAIL rand_%0d acc=%h sat=%b kovf=%b lat=%0d exp acc=%h sat=%b kovf=0 lat=3", f, acc_o, sat_o, kovf_o, lat, e_acc, e_sat);
      end
      $display("[TB] rand %0d: n=%0d mode=%0d acc=%h sat=%b", f, n, mode, acc_o, sat_o);
      for (int s = 0; s < stall; s++) tick;
      consume;
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    vld_i      = 1'b0;
    last_i     = 1'b0;
    win        = '0;
    din        = '0;
    rnd_mode_i = 2'd0;
    rdy_i      = 1'b0;
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_kovf;
    test_hold_stall;
    test_reset_midframe;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
